// File: rtl/io_if_pkg.sv
// Shared types and constants for the io_interface_bank register-bank slave.
// Parity support is enabled by defining IO_IF_PARITY_EN (see io_if_ram).
package io_if_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } io_state_e;

    localparam int STATUS_BUSY       = 0;
    localparam int STATUS_RANGE_ERR  = 1;
    localparam int STATUS_PARITY_ERR = 2;
    localparam int STATUS_WCNT_LSB   = 4;

    localparam int WCNT_W = 4;
    localparam logic [WCNT_W-1:0] WCNT_MAX = '1;

    // Clear is applied first so that an increment in the same cycle survives it.
    function automatic logic [WCNT_W-1:0] wcnt_next(input logic [WCNT_W-1:0] cnt,
                                                   input logic              clr,
                                                   input logic              inc);
        logic [WCNT_W-1:0] base;
        base = clr ? '0 : cnt;
        if (inc && (base != WCNT_MAX)) begin
            base = base + 1'b1;
        end
        return base;
    endfunction

endpackage

// File: rtl/io_interface_bank_if.sv
// Request/response channel bundle between a bus master and io_interface_bank.
// No configuration macros affect this file.
interface io_interface_bank_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    localparam int BE_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/io_if_ram.sv
// DEPTH x DATA_W synchronous RAM, one storage array per byte lane, registered read.
// IO_IF_PARITY_EN adds an even-parity bit per lane, checked on the registered read data.
module io_if_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic                clk,
    input  logic                we,
    input  logic                re,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   rdata,
    output logic                parity_err
);
    localparam int LANES = DATA_W / 8;

    logic [LANES-1:0] lane_perr;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_q;

            always_ff @(posedge clk) begin
                if (we && be[gi]) begin
                    mem[addr] <= wdata[gi*8 +: 8];
                end
                if (re) begin
                    rd_q <= mem[addr];
                end
            end

            assign rdata[gi*8 +: 8] = rd_q;

`ifdef IO_IF_PARITY_EN
            logic par_mem [DEPTH];
            logic rd_par_q;

            always_ff @(posedge clk) begin
                if (we && be[gi]) begin
                    par_mem[addr] <= ^wdata[gi*8 +: 8];
                end
                if (re) begin
                    rd_par_q <= par_mem[addr];
                end
            end

            // Stored bit makes the 9-bit lane even; any odd total is a mismatch.
            assign lane_perr[gi] = (^rd_q) ^ rd_par_q;
`else
            assign lane_perr[gi] = 1'b0;
`endif
        end
    endgenerate

    assign parity_err = |lane_perr;

endmodule

// File: rtl/io_interface_bank.sv
// Handshaked register-bank slave: one outstanding request, range check, sticky status.
// Optional per-lane parity checking is enabled with IO_IF_PARITY_EN.
module io_interface_bank
    import io_if_pkg::*;
#(
    parameter int          DATA_W = 32,
    parameter int          ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic                clk,
    input  logic                reset,
    io_interface_bank_if.slave  bus,
    input  logic                status_clr,
    output logic [7:0]          status
);
    localparam int BE_W   = DATA_W / 8;
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    io_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              write_q, write_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              range_sticky_q, range_sticky_d;
    logic              parity_sticky_q, parity_sticky_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    logic              in_range;
    logic              range_set;
    logic              parity_set;
    logic              wcnt_inc;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_perr;

    assign in_range = (32'(addr_q) < DEPTH);

    // Reset is folded into the write enable so an abandoned ACCESS never lands in RAM.
    assign ram_we = (state_q == ACCESS) && write_q && in_range && reset;
    assign ram_re = (state_q == ACCESS) && !write_q && in_range;

    io_if_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk        (clk),
        .we         (ram_we),
        .re         (ram_re),
        .addr       (addr_q[RAM_AW-1:0]),
        .wdata      (wdata_q),
        .be         (be_q),
        .rdata      (ram_rdata),
        .parity_err (ram_perr)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        write_d     = write_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        range_set   = 1'b0;
        parity_set  = 1'b0;
        wcnt_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    write_d = bus.req_write;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                wcnt_inc = write_q && in_range;
                state_d  = RESP;
            end
            RESP: begin
                // First RESP cycle loads the response from the registered RAM read.
                if (!rsp_valid_q) begin
                    range_set   = !in_range;
                    parity_set  = in_range && !write_q && ram_perr;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = range_set || parity_set;
                    rsp_rdata_d = (in_range && !write_q) ? ram_rdata : '0;
                end else if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        range_sticky_d  = range_set  || (range_sticky_q  && !status_clr);
        parity_sticky_d = parity_set || (parity_sticky_q && !status_clr);
        wcnt_d          = wcnt_next(wcnt_q, status_clr, wcnt_inc);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            wdata_q         <= '0;
            be_q            <= '0;
            write_q         <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_err_q       <= 1'b0;
            range_sticky_q  <= 1'b0;
            parity_sticky_q <= 1'b0;
            wcnt_q          <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            be_q            <= be_d;
            write_q         <= write_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_err_q       <= rsp_err_d;
            range_sticky_q  <= range_sticky_d;
            parity_sticky_q <= parity_sticky_d;
            wcnt_q          <= wcnt_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    always_comb begin
        status                                   = '0;
        status[STATUS_BUSY]                      = (state_q != IDLE);
        status[STATUS_RANGE_ERR]                 = range_sticky_q;
        status[STATUS_PARITY_ERR]                = parity_sticky_q;
        status[STATUS_WCNT_LSB +: WCNT_W]        = wcnt_q;
    end

endmodule

// File: tb/tb_io_interface_bank.sv
// Scoreboard-driven bench for io_interface_bank (DEPTH=200); parity test runs only with IO_IF_PARITY_EN.
module tb_io_interface_bank;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       status_clr;
    logic [7:0] status;

    int tests_run;
    int tests_failed;

    exp_t sb_q[$];

    int   m_wcnt;
    logic m_rng;
    logic m_par;

    io_interface_bank_if #(.DATA_W(32), .ADDR_W(8)) bus ();

    io_interface_bank #(
        .DATA_W (32),
        .ADDR_W (8),
        .DEPTH  (200)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .status_clr (status_clr),
        .status     (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    function automatic logic [7:0] exp_status();
        logic [3:0] c;
        c = 4'(m_wcnt);
        return {c, 1'b0, m_par, m_rng, 1'b0};
    endfunction

    // Drives one request, checks latency and the response against the scoreboard.
    // hold > 0 keeps rsp_ready low that many cycles while offering a stray request.
    task automatic issue(input string name, input logic wr, input logic [7:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        exp_t        e;
        int          lat;
        int          wc;
        logic [31:0] held_rdata;
        logic        held_err;

        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb_q.push_back(e);
        if (hold > 0) bus.rsp_ready = 1'b0;

        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        wc = 0;
        while (!bus.req_ready && wc < 20) begin
            @(posedge clk); #1; wc++;
        end
        if (!bus.req_ready) begin
            tests_run++; tests_failed++;
            $display("FAIL %s accept: req_ready stayed 0", name);
            bus.req_valid = 1'b0;
            void'(sb_q.pop_front());
            return;
        end
        @(posedge clk); #1;
        // Scramble fields after acceptance; the DUT must use the captured copy.
        bus.req_valid = 1'b0;
        bus.req_write = ~wr;
        bus.req_addr  = ~addr;
        bus.req_wdata = ~wdata;
        bus.req_be    = ~be;

        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        tests_run++;
        if (lat !== 2) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d cycles, expected 2", name, lat);
        end
        if (!bus.rsp_valid) begin
            void'(sb_q.pop_front());
            bus.rsp_ready = 1'b1;
            return;
        end

        e = sb_q.pop_front();
        tests_run++;
        if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
            tests_failed++;
            $display("FAIL %s rsp: got rdata=%h err=%b, expected rdata=%h err=%b",
                     name, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
        end

        if (hold > 0) begin
            held_rdata    = bus.rsp_rdata;
            held_err      = bus.rsp_err;
            bus.req_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                tests_run++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== held_rdata ||
                    bus.rsp_err !== held_err || bus.req_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s hold[%0d]: valid=%b rdata=%h err=%b req_ready=%b, expected 1 %h %b 0",
                             name, i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready,
                             held_rdata, held_err);
                end
            end
            bus.req_valid = 1'b0;
            bus.rsp_ready = 1'b1;
        end

        @(posedge clk); #1;
        tests_run++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s complete: rsp_valid=%b req_ready=%b, expected 0 1",
                     name, bus.rsp_valid, bus.req_ready);
        end
        $display("[TB] %s %s addr=%h wdata=%h be=%h -> rdata=%h err=%b lat=%0d",
                 name, wr ? "WR" : "RD", addr, wdata, be, e.rdata, e.err, lat);
    endtask

    task automatic model_write(input logic [7:0] addr);
        if (addr < 8'd200) begin
            if (m_wcnt < 15) m_wcnt++;
        end else begin
            m_rng = 1'b1;
        end
    endtask

    task automatic check_status(input string name);
        tests_run++;
        if (status !== exp_status()) begin
            tests_failed++;
            $display("FAIL %s status: got %h, expected %h", name, status, exp_status());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || status !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset: req_ready=%b rsp_valid=%b status=%h, expected 1 0 00",
                     bus.req_ready, bus.rsp_valid, status);
        end
        reset  = 1'b1;
        m_wcnt = 0; m_rng = 1'b0; m_par = 1'b0;
    endtask

    task automatic test_write_read();
        issue("wr_full", 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
        model_write(8'h10);
        check_status("wr_full");
        issue("rd_full", 1'b0, 8'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);
        check_status("rd_full");
        issue("wr_last", 1'b1, 8'hC7, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 0);
        model_write(8'hC7);
        issue("rd_last", 1'b0, 8'hC7, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 0);
        check_status("rd_last");
    endtask

    task automatic test_byte_enable();
        issue("wr_be5", 1'b1, 8'h10, 32'h11223344, 4'b0101, 32'h0, 1'b0, 0);
        model_write(8'h10);
        issue("rd_be5", 1'b0, 8'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 0);
        issue("wr_be0", 1'b1, 8'h10, 32'h55667788, 4'b0000, 32'h0, 1'b0, 0);
        model_write(8'h10);
        issue("rd_be0", 1'b0, 8'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 0);
        check_status("be");
    endtask

    task automatic test_range();
        issue("rd_oor", 1'b0, 8'hC8, 32'h0, 4'h0, 32'h0, 1'b1, 0);
        m_rng = 1'b1;
        check_status("rd_oor");
        issue("wr_oor", 1'b1, 8'hFF, 32'h12345678, 4'hF, 32'h0, 1'b1, 0);
        model_write(8'hFF);
        check_status("wr_oor");
        status_clr = 1'b1;
        @(posedge clk); #1;
        status_clr = 1'b0;
        m_rng = 1'b0; m_par = 1'b0; m_wcnt = 0;
        check_status("status_clr");
    endtask

    task automatic test_backpressure();
        issue("rd_hold", 1'b0, 8'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 5);
        issue("rd_after_hold", 1'b0, 8'hC7, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 0);
        check_status("hold");
    endtask

    task automatic test_reset_mid();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h20;
        bus.req_wdata = 32'hA0A0A0A0;
        bus.req_be    = 4'hF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        tests_run++;
        if (status[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid busy: got %b, expected 1", status[0]);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        m_wcnt = 0; m_rng = 1'b0; m_par = 1'b0;
        tests_run++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || status !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_mid: req_ready=%b rsp_valid=%b status=%h, expected 1 0 00",
                     bus.req_ready, bus.rsp_valid, status);
        end
        $display("[TB] reset_mid abandoned write at 20");
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 16; i++) begin
            issue("wr_sat", 1'b1, 8'(8'h40 + i), 32'(i * 32'h01010101), 4'hF, 32'h0, 1'b0, 0);
            model_write(8'(8'h40 + i));
            check_status("wr_sat");
        end
        issue("rd_sat", 1'b0, 8'h4B, 32'h0, 4'h0, 32'h0B0B0B0B, 1'b0, 0);
    endtask

`ifdef IO_IF_PARITY_EN
    task automatic test_parity();
        issue("wr_par", 1'b1, 8'h30, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, 0);
        model_write(8'h30);
        issue("rd_par_ok", 1'b0, 8'h30, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, 0);
        dut.u_ram.g_lane[1].par_mem[8'h30] = ~dut.u_ram.g_lane[1].par_mem[8'h30];
        issue("rd_par_bad", 1'b0, 8'h30, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b1, 0);
        m_par = 1'b1;
        check_status("parity");
    endtask
`endif

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        reset         = 1'b0;
        status_clr    = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.rsp_ready = 1'b1;
        m_wcnt = 0; m_rng = 1'b0; m_par = 1'b0;

        test_reset();
        test_write_read();
        test_byte_enable();
        test_range();
        test_backpressure();
        test_reset_mid();
        test_saturate();
`ifdef IO_IF_PARITY_EN
        test_parity();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
